// File: rtl/fir_param_filter.sv
// Pipelined direct-form FIR filter with a run-time coefficient register file.
// A 3-stage pipeline multiplies, sums with round-half-up, then shifts and saturates.
module fir_param_filter #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int SHIFT  = 7,
   parameter int ADDR_W = $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     coef_we,
   input  logic [ADDR_W-1:0]        coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     sat_flag
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + $clog2(TAPS);

   localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1) << (SHIFT - 1);
   localparam logic signed [ACC_W-1:0] MAX_POS = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] MIN_NEG = -(ACC_W'(1) << (DATA_W - 1));

   logic signed [COEF_W-1:0] r_coef  [TAPS];
   logic signed [DATA_W-1:0] r_delay [TAPS-1];
   logic signed [PROD_W-1:0] r_prod  [TAPS];
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [DATA_W-1:0] r_dout;
   logic                     r_sat;
   logic                     r_v1;
   logic                     r_v2;
   logic                     r_v3;

   logic signed [DATA_W-1:0] w_tap [TAPS];
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_shift;
   logic                     w_satHi;
   logic                     w_satLo;

   // Addresses that match no tap fall through the loop and leave the file unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
      end else if (coef_we) begin
         for (int i = 0; i < TAPS; i++) begin
            if (coef_addr == ADDR_W'(i)) r_coef[i] <= coef_wdata;
         end
      end
   end

   always_comb begin
      w_tap[0] = data_in;
      for (int i = 1; i < TAPS; i++) w_tap[i] = r_delay[i-1];
   end

   // The delay line only moves on accepted samples, so gaps never shift in zeros.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS - 1; i++) r_delay[i] <= '0;
      end else if (in_valid) begin
         r_delay[0] <= data_in;
         for (int i = 1; i < TAPS - 1; i++) r_delay[i] <= r_delay[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) r_prod[i] <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < TAPS; i++) r_prod[i] <= PROD_W'(w_tap[i]) * PROD_W'(r_coef[i]);
         end
      end
   end

   always_comb begin
      w_sum = ROUND;
      for (int i = 0; i < TAPS; i++) w_sum = w_sum + ACC_W'(r_prod[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
         r_v2  <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) r_acc <= w_sum;
      end
   end

   always_comb begin
      w_shift = r_acc >>> SHIFT;
      w_satHi = (w_shift > MAX_POS);
      w_satLo = (w_shift < MIN_NEG);
   end

   // Output register holds between valid samples; the saturation flag is sticky.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout <= '0;
         r_sat  <= 1'b0;
         r_v3   <= 1'b0;
      end else begin
         r_v3 <= r_v2;
         if (r_v2) begin
            if (w_satHi) begin
               r_dout <= {1'b0, {(DATA_W-1){1'b1}}};
               r_sat  <= 1'b1;
            end else if (w_satLo) begin
               r_dout <= {1'b1, {(DATA_W-1){1'b0}}};
               r_sat  <= 1'b1;
            end else begin
               r_dout <= w_shift[DATA_W-1:0];
            end
         end
      end
   end

   assign out_valid = r_v3;
   assign data_out  = r_dout;
   assign sat_flag  = r_sat;

endmodule

// File: tb/tb_fir_param_filter.sv
// Scoreboard bench for fir_param_filter: stimulus pushes hand-computed results,
// a negedge monitor pops them on out_valid and checks value, flag and arrival cycle.
module tb_fir_param_filter;

   localparam int DATA_W = 16;
   localparam int COEF_W = 8;
   localparam int TAPS   = 4;
   localparam int SHIFT  = 7;
   localparam int ADDR_W = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     coef_we;
   logic [ADDR_W-1:0]        coef_addr;
   logic signed [COEF_W-1:0] coef_wdata;
   logic                     in_valid;
   logic signed [DATA_W-1:0] data_in;
   logic                     out_valid;
   logic signed [DATA_W-1:0] data_out;
   logic                     sat_flag;

   typedef struct {
      int   data;
      logic sat;
      int   cycle;
   } exp_t;

   exp_t scoreQ[$];
   int   cycleCount  = 0;
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   lastExp     = 0;
   bit   monitorOn   = 1'b0;
   bit   clearNext   = 1'b0;

   fir_param_filter #(
      .DATA_W(DATA_W),
      .COEF_W(COEF_W),
      .TAPS  (TAPS),
      .SHIFT (SHIFT),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_wdata(coef_wdata),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .out_valid (out_valid),
      .data_out  (data_out),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Drives one cycle; a reset discards every expectation that would arrive after this cycle.
   task automatic applyStimulus(input logic rst, input logic v, input int d, input logic we,
                                input int addr, input int wdata, input int expData, input logic expSat);
      reset      = rst;
      in_valid   = v;
      data_in    = DATA_W'(d);
      coef_we    = we;
      coef_addr  = ADDR_W'(addr);
      coef_wdata = COEF_W'(wdata);
      if (rst) begin
         while (scoreQ.size() > 0 && scoreQ[$].cycle > cycleCount) void'(scoreQ.pop_back());
      end else if (v) begin
         scoreQ.push_back('{expData, expSat, cycleCount + 3});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic writeCoef(input int addr, input int val);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, addr, val, 0, 1'b0);
   endtask

   task automatic loadAll(input int val);
      for (int i = 0; i < TAPS; i++) writeCoef(i, val);
   endtask

   task automatic sample(input int d, input int expData, input logic expSat);
      applyStimulus(1'b0, 1'b1, d, 1'b0, 0, 0, expData, expSat);
   endtask

   task automatic doReset(input logic v, input int d);
      applyStimulus(1'b1, v, d, 1'b0, 0, 0, 0, 1'b0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset data_out", data_out, 0);
      checkOutput("reset sat_flag", sat_flag, 0);
   endtask

   // Monitor: every cycle either an expected result arrives or data_out must hold.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (monitorOn) begin
            if (clearNext) lastExp = 0;
            clearNext = reset;
            if (out_valid === 1'b1) begin
               if (scoreQ.size() == 0) begin
                  checkOutput("unexpected out_valid", out_valid, 0);
               end else begin
                  e = scoreQ.pop_front();
                  checkOutput("data_out", data_out, e.data);
                  checkOutput("sat_flag", sat_flag, e.sat);
                  checkOutput("output cycle", cycleCount, e.cycle);
                  lastExp = e.data;
               end
            end else begin
               checkOutput("hold data_out", data_out, lastExp);
            end
         end
      end
   end

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      data_in    = '0;
      coef_we    = 1'b0;
      coef_addr  = '0;
      coef_wdata = '0;
      @(posedge clk);
      #1;
      monitorOn = 1'b1;
      checkOutput("init out_valid", out_valid, 0);
      checkOutput("init data_out", data_out, 0);
      checkOutput("init sat_flag", sat_flag, 0);

      // Moving average step response
      loadAll(32);
      sample(100, 25, 1'b0);
      sample(100, 50, 1'b0);
      sample(100, 75, 1'b0);
      sample(100, 100, 1'b0);
      sample(100, 100, 1'b0);
      idle(4);

      // Impulse through taps 1,2,3,4
      doReset(1'b0, 0);
      writeCoef(0, 1);
      writeCoef(1, 2);
      writeCoef(2, 3);
      writeCoef(3, 4);
      sample(1000, 8, 1'b0);
      sample(0, 16, 1'b0);
      sample(0, 23, 1'b0);
      sample(0, 31, 1'b0);
      sample(0, 0, 1'b0);
      idle(4);

      // Negative rounding on tap 0
      doReset(1'b0, 0);
      writeCoef(0, 64);
      sample(-1, 0, 1'b0);
      writeCoef(0, 65);
      sample(-1, -1, 1'b0);
      idle(4);

      // Positive saturation
      doReset(1'b0, 0);
      loadAll(127);
      sample(32767, 32511, 1'b0);
      sample(32767, 32767, 1'b1);
      sample(32767, 32767, 1'b1);
      sample(32767, 32767, 1'b1);
      idle(4);

      // Negative saturation
      doReset(1'b0, 0);
      loadAll(127);
      sample(-32768, -32512, 1'b0);
      sample(-32768, -32768, 1'b1);
      sample(-32768, -32768, 1'b1);
      idle(4);

      // Reset with three samples in flight, the last accepted in the reset cycle
      sample(-32768, -32768, 1'b1);
      sample(-32768, -32768, 1'b1);
      doReset(1'b1, -32768);
      idle(4);
      sample(500, 0, 1'b0);
      idle(4);

      // Gappy input with a coefficient write colliding with an accept
      doReset(1'b0, 0);
      writeCoef(0, 64);
      writeCoef(1, 32);
      applyStimulus(1'b0, 1'b1, 200, 1'b1, 0, 0, 100, 1'b0);
      applyStimulus(1'b0, 1'b0, 999, 1'b0, 0, 0, 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 999, 1'b0, 0, 0, 0, 1'b0);
      sample(300, 50, 1'b0);
      idle(4);

      for (int i = 0; i < 50 && scoreQ.size() > 0; i++) @(posedge clk);
      if (scoreQ.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain: %0d expected outputs never arrived, required 0", scoreQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fir_param_filter.md
# fir_param_filter

Parametrised, pipelined direct-form FIR filter, the next generation of the fixed 4-tap moving-average filter. Tap count, data width and coefficient width are generic. Coefficients live in an internal register file that is written at run time. The block adds a valid-qualified sample stream, a fixed 3-cycle latency, rounding, saturation and a sticky overflow flag. It sits between the sample source and downstream analysis logic, and is the filter instance the GE-evolved coefficient sets are loaded into.

## Interface
- `DATA_W`, 16 — signed input/output sample width.
- `COEF_W`, 8 — signed coefficient width.
- `TAPS`, 4 — number of coefficients (≥2).
- `SHIFT`, 7 — fractional bits of coefficients (scale 2^SHIFT = 128).
- `ADDR_W`, $clog2(TAPS) — coefficient address width (derived).

Ports:
- `clk` — input, 1 — single clock; all logic on rising edge.
- `reset` — input, 1 — synchronous, active-high; clears all state.
- `coef_we` — input, 1 — coefficient write strobe.
- `coef_addr` — input, ADDR_W — tap index to write.
- `coef_wdata` — input, COEF_W — signed coefficient value.
- `in_valid` — input, 1 — `data_in` holds a new sample this cycle.
- `data_in` — input, DATA_W — signed sample.
- `out_valid` — output, 1 — `data_out` holds a filtered sample this cycle.
- `data_out` — output, DATA_W — signed, rounded, saturated result.
- `sat_flag` — output, 1 — sticky; set when any output saturated.

## Operation
- **Reset values:**
  - Delay line, product registers, accumulator, `coef[0..TAPS-1]`, `data_out`, `out_valid` and `sat_flag` are all 0.
  - Reset is synchronous. Asserting it mid-stream discards every in-flight sample, and `out_valid` is 0 from the cycle after the reset edge.
- **Coefficient write:**
  - When `coef_we` is high, `coef[coef_addr]` ← `coef_wdata` at the end of the cycle.
  - A write with `coef_addr` ≥ TAPS is ignored.
  - A sample accepted in the same cycle as a write uses the old coefficient value.
- **Delay line:**
  - TAPS-1 registers `x[1..TAPS-1]`, with `x[0]` = `data_in`.
  - Advances only on edges where `in_valid` is 1. During gaps it holds its contents; there is no decay and no zero insertion.
- **Stage 1 (edge of accept):** `p[i]` ← `x[i]·coef[i]`, signed, DATA_W+COEF_W bits.
- **Stage 2:**
  - `acc` ← Σ `p[i]` + 2^(SHIFT-1), width DATA_W+COEF_W+$clog2(TAPS). The sum never wraps.
  - The added constant rounds half toward +∞.
- **Stage 3:**
  - `r` = `acc` >>> SHIFT (arithmetic shift).
  - If `r` > 2^(DATA_W-1)-1, `data_out` ← max positive; if `r` < -2^(DATA_W-1), `data_out` ← min negative; otherwise `data_out` ← `r`.
  - On a clamp in either direction, `sat_flag` ← 1.
- **Valid path:**
  - A 3-bit shift register (v1, v2, v3) follows the data pipeline; `out_valid` = v3.
  - There is no back-pressure, and each accepted sample produces exactly one `out_valid` pulse.
- **Warm-up:** unfilled taps contain 0, and outputs are produced from the first accepted sample.
- **Stall behaviour:** `data_out` holds its last value while `out_valid` is 0.
- `sat_flag` clears only on reset.

## Timing
- Latency is fixed: `in_valid` = 1 in cycle n gives `out_valid` = 1 with the matching `data_out` in cycle n+3.
- Throughput is one sample per cycle. Back-to-back `in_valid` gives back-to-back `out_valid`.
- Gaps in `in_valid` reappear unchanged, 3 cycles later, as gaps in `out_valid`.
- A coefficient written in cycle n first affects a sample accepted in cycle n+1, whose output appears in cycle n+4.
- `sat_flag` rises in the same cycle as the saturated `out_valid`.
- `reset` high in cycle n gives all outputs 0 in cycle n+1. A sample accepted in cycle n is lost.

## Test plan
All cases use DATA_W=16, COEF_W=8, TAPS=4, SHIFT=7.

- **Moving average (step):** all coefficients 0x20; continuous `data_in`=100 from cycle 0. Required: `out_valid` from cycle 3, with `data_out` = 25, 50, 75, 100, 100…
- **Impulse:** coefficients 1, 2, 3, 4; `data_in`=1000 once, then zeros. Required: `data_out` = 8, 16, 23, 31, then 0. This checks round-half-up.
- **Negative rounding:** coefficient 64, then 65 on tap 0, other taps 0; `data_in`=-1. Required: `data_out` = 0, then -1.
- **Saturation:** all coefficients 127.
  - `data_in`=32767 continuously: `data_out` reaches 32767 and `sat_flag`=1.
  - Reset, then `data_in`=-32768 continuously: `data_out` reaches -32768 and `sat_flag`=1.
- **Gappy input and write collision:** `in_valid` pattern 1,0,0,1; a coefficient write in the same cycle as an accept. Required: `out_valid` pattern repeats exactly 3 cycles later, the delay line holds through the gap, and the colliding sample uses the old coefficient.
- **Reset mid-stream:** `reset` for 1 cycle while 3 samples are in flight. Required:
  - No further `out_valid` from those samples.
  - Coefficients read as 0, so the next accepted sample gives `data_out`=0.
  - `sat_flag`=0.
